// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move tick, direction latch with reversal rejection,
// serial wall/self collision scan ahead of each step strobe, length/food tracking.
//
// state | meaning
// IDLE  | waiting for start, snake stopped
// RUN   | move tick counting, keys accepted
// PAUSE | tick counter held, keys dropped
// CHECK | scanning tail segments against next head, one per cycle
// STEP  | collision-free: issue step (and eat) on the way back to RUN
// OVER  | collision seen, game_over held until next start
module snake_game_ctrl #(
    parameter int GRID_W   = 80,
    parameter int GRID_H   = 60,
    parameter int SEG_N    = 15,
    parameter int LEN_INIT = 3,
    parameter int TICK_DIV = 15165696
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 key_valid,
    input  logic [3:0]           key_dir,
    input  logic [6:0]           head_x,
    input  logic [5:0]           head_y,
    input  logic [7*SEG_N-1:0]   tail_x,
    input  logic [6*SEG_N-1:0]   tail_y,
    input  logic [6:0]           food_x,
    input  logic [5:0]           food_y,
    output logic [4:0]           direction,
    output logic                 step,
    output logic                 new_game,
    output logic                 eat,
    output logic [3:0]           length,
    output logic                 game_over
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (SEG_N > 1) ? $clog2(SEG_N) : 1;

    localparam logic [3:0] D_UP    = 4'b1000;
    localparam logic [3:0] D_LEFT  = 4'b0100;
    localparam logic [3:0] D_DOWN  = 4'b0010;
    localparam logic [3:0] D_RIGHT = 4'b0001;
    localparam logic [4:0] D_STOP  = 5'b10000;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_CHECK, S_STEP, S_OVER} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic            hit;
    logic [3:0]      dir_cur;
    logic [3:0]      dir_pend;

    logic [7:0]      nx;
    logic [7:0]      ny;
    logic            wall;
    logic [6:0]      seg_x;
    logic [5:0]      seg_y;
    logic            seg_hit;
    logic [3:0]      dir_opp;
    logic            key_ok;

    // Next head cell; left/up walls are judged on the current head to avoid wrap.
    always_comb begin
        nx   = {1'b0, head_x};
        ny   = {2'b00, head_y};
        wall = 1'b0;
        case (dir_pend)
            D_RIGHT: begin
                nx   = {1'b0, head_x} + 8'd1;
                wall = (nx >= 8'(GRID_W));
            end
            D_LEFT: begin
                nx   = {1'b0, head_x} - 8'd1;
                wall = (head_x == 7'd0);
            end
            D_DOWN: begin
                ny   = {2'b00, head_y} + 8'd1;
                wall = (ny >= 8'(GRID_H));
            end
            D_UP: begin
                ny   = {2'b00, head_y} - 8'd1;
                wall = (head_y == 6'd0);
            end
            default: ;
        endcase
    end

    assign seg_x   = tail_x[7*int'(idx) +: 7];
    assign seg_y   = tail_y[6*int'(idx) +: 6];
    assign seg_hit = (int'(idx) < int'(length)) && ({1'b0, seg_x} == nx) && ({2'b00, seg_y} == ny);

    assign dir_opp = {dir_cur[1], dir_cur[0], dir_cur[3], dir_cur[2]};
    assign key_ok  = key_valid && (key_dir != 4'd0) && ((key_dir & (key_dir - 4'd1)) == 4'd0)
                     && (key_dir != dir_opp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            direction <= D_STOP;
            step      <= 1'b0;
            eat       <= 1'b0;
            new_game  <= 1'b0;
            game_over <= 1'b0;
            length    <= 4'(LEN_INIT);
            dir_cur   <= D_RIGHT;
            dir_pend  <= D_RIGHT;
            cnt       <= '0;
            idx       <= '0;
            hit       <= 1'b0;
        end else begin
            step     <= 1'b0;
            eat      <= 1'b0;
            new_game <= 1'b0;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        new_game  <= 1'b1;
                        length    <= 4'(LEN_INIT);
                        dir_cur   <= D_RIGHT;
                        dir_pend  <= D_RIGHT;
                        game_over <= 1'b0;
                        cnt       <= '0;
                        direction <= {1'b0, D_RIGHT};
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (key_ok) dir_pend <= key_dir;
                    if (pause) begin
                        direction <= D_STOP;
                        state     <= S_PAUSE;
                    end else if (cnt == CW'(TICK_DIV - 1)) begin
                        cnt   <= '0;
                        idx   <= '0;
                        hit   <= 1'b0;
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (pause) begin
                        direction <= {1'b0, dir_cur};
                        state     <= S_RUN;
                    end
                end
                S_CHECK: begin
                    if (idx == IW'(SEG_N - 1)) begin
                        if (hit || seg_hit || wall) begin
                            game_over <= 1'b1;
                            direction <= D_STOP;
                            state     <= S_OVER;
                        end else begin
                            direction <= {1'b0, dir_pend};
                            state     <= S_STEP;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                        hit <= hit | seg_hit | wall;
                    end
                end
                S_STEP: begin
                    step      <= 1'b1;
                    dir_cur   <= dir_pend;
                    direction <= {1'b0, dir_pend};
                    if (nx == {1'b0, food_x} && ny == {2'b00, food_y}) begin
                        eat <= 1'b1;
                        if (length < 4'(SEG_N)) length <= length + 4'd1;
                    end
                    state <= S_RUN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with a short tick (TICK_DIV=4), SEG_N=15, LEN_INIT=3.
module tb_snake_game_ctrl;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         key_valid = 1'b0;
    logic [3:0]   key_dir = 4'd0;
    logic [6:0]   head_x = 7'd10;
    logic [5:0]   head_y = 6'd10;
    logic [104:0] tail_x = '0;
    logic [89:0]  tail_y = '0;
    logic [6:0]   food_x = 7'd70;
    logic [5:0]   food_y = 6'd50;
    logic [4:0]   direction;
    logic         step;
    logic         new_game;
    logic         eat;
    logic [3:0]   length;
    logic         game_over;

    int checks = 0;
    int failures = 0;

    snake_game_ctrl #(
        .GRID_W(80), .GRID_H(60), .SEG_N(15), .LEN_INIT(3), .TICK_DIV(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .key_valid(key_valid), .key_dir(key_dir),
        .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
        .food_x(food_x), .food_y(food_y),
        .direction(direction), .step(step), .new_game(new_game), .eat(eat),
        .length(length), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    task automatic send_key(input logic [3:0] k);
        key_dir   = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Counts negedges until step or game_over is seen, bounded by max_cyc.
    task automatic wait_ev(input int max_cyc, output int n, output bit got_step, output bit got_over);
        n = 0;
        got_step = 1'b0;
        got_over = 1'b0;
        while (n < max_cyc && !got_step && !got_over) begin
            @(negedge clk);
            n++;
            got_step = step;
            got_over = game_over;
        end
        check_val("ev_timeout", 32'(got_step | got_over), 32'd1);
    endtask

    initial begin
        int  n;
        bit  s;
        bit  o;
        int  steps;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("rst_dir", 32'(direction), 32'h10);
        check_val("rst_step", 32'(step), 32'd0);
        check_val("rst_new_game", 32'(new_game), 32'd0);
        check_val("rst_over", 32'(game_over), 32'd0);
        check_val("rst_len", 32'(length), 32'd3);

        pulse_start();
        check_val("new_game", 32'(new_game), 32'd1);
        wait_ev(40, n, s, o);
        check_val("first_latency", 32'(n), 32'd20);
        check_val("first_step", 32'(s), 32'd1);
        check_val("first_dir", 32'(direction), 32'h01);
        check_val("first_no_eat", 32'(eat), 32'd0);

        pulse_start();
        check_val("start_ignored_run", 32'(new_game), 32'd0);

        send_key(4'b0100);
        wait_ev(40, n, s, o);
        check_val("reverse_rejected", 32'(direction), 32'h01);

        send_key(4'b0010);
        wait_ev(40, n, s, o);
        check_val("key_down", 32'(direction), 32'h02);

        send_key(4'b0011);
        wait_ev(40, n, s, o);
        check_val("key_not_onehot", 32'(direction), 32'h02);

        @(negedge clk);
        pulse_pause();
        check_val("pause_dir", 32'(direction), 32'h10);
        steps = 0;
        key_dir = 4'b0001;
        key_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            key_valid = 1'b0;
            if (step) steps++;
        end
        check_val("pause_no_step", 32'(steps), 32'd0);
        pulse_pause();
        wait_ev(40, n, s, o);
        check_val("resume_latency", 32'(n), 32'd19);
        check_val("pause_key_dropped", 32'(direction), 32'h02);

        head_x = 7'd32; head_y = 6'd24;
        food_x = 7'd33; food_y = 6'd24;
        send_key(4'b0001);
        wait_ev(40, n, s, o);
        check_val("eat_step", 32'(s), 32'd1);
        check_val("eat_pulse", 32'(eat), 32'd1);
        check_val("eat_len4", 32'(length), 32'd4);
        for (int i = 0; i < 11; i++) wait_ev(40, n, s, o);
        check_val("len_reach15", 32'(length), 32'd15);
        wait_ev(40, n, s, o);
        check_val("len_sat_eat", 32'(eat), 32'd1);
        check_val("len_sat15", 32'(length), 32'd15);

        head_x = 7'd79; head_y = 6'd10;
        food_x = 7'd70; food_y = 6'd50;
        wait_ev(40, n, s, o);
        check_val("wall_over", 32'(o), 32'd1);
        check_val("wall_no_step", 32'(s), 32'd0);
        check_val("wall_dir", 32'(direction), 32'h10);

        head_x = 7'd10; head_y = 6'd10;
        pulse_start();
        check_val("restart_new_game", 32'(new_game), 32'd1);
        check_val("restart_len", 32'(length), 32'd3);
        check_val("restart_over_clr", 32'(game_over), 32'd0);
        check_val("restart_dir", 32'(direction), 32'h01);

        tail_x[27:21] = 7'd11; tail_y[23:18] = 6'd10;
        wait_ev(40, n, s, o);
        check_val("seg3_beyond_len_step", 32'(s), 32'd1);
        check_val("seg3_beyond_len_over", 32'(o), 32'd0);

        tail_x[20:14] = 7'd11; tail_y[17:12] = 6'd10;
        wait_ev(40, n, s, o);
        check_val("self_hit_over", 32'(o), 32'd1);
        check_val("self_hit_no_step", 32'(s), 32'd0);

        tail_x = '0; tail_y = '0;
        head_x = 7'd10; head_y = 6'd0;
        pulse_start();
        send_key(4'b1000);
        wait_ev(40, n, s, o);
        check_val("up_wall_over", 32'(o), 32'd1);
        check_val("up_wall_no_step", 32'(s), 32'd0);

        head_y = 6'd10;
        pulse_start();
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_check_dir", 32'(direction), 32'h10);
        check_val("rst_check_len", 32'(length), 32'd3);
        reset = 1'b0;
        steps = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (step || new_game) steps++;
        end
        check_val("rst_check_idle", 32'(steps), 32'd0);
        check_val("rst_check_idle_dir", 32'(direction), 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
